// File: rtl/mig_pkg.sv
// Shared types for the sequential MIG evaluator: node encoding, FSM states, index-width helper.
package mig_pkg;

  function automatic int idx_w(input int num_in, input int max_nodes);
    return $clog2(num_in + max_nodes + 1);
  endfunction

  localparam int NUM_IN_DEF    = 7;
  localparam int MAX_NODES_DEF = 8;
  localparam int NODE_IDX_W    = idx_w(NUM_IN_DEF, MAX_NODES_DEF);

  // Field order matches the cfg_data bus, MSB first.
  typedef struct packed {
    logic                  inv_a;
    logic [NODE_IDX_W-1:0] idx_a;
    logic                  inv_b;
    logic [NODE_IDX_W-1:0] idx_b;
    logic                  inv_c;
    logic [NODE_IDX_W-1:0] idx_c;
  } node_t;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_t;

endpackage

// File: rtl/mig_maj3.sv
// Combinational 3-input majority with per-input complement; zero latency, no flow control.
module mig_maj3 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic inv_a,
  input  logic inv_b,
  input  logic inv_c,
  output logic y
);

  logic aa, bb, cc;

  assign aa = a ^ inv_a;
  assign bb = b ^ inv_b;
  assign cc = c ^ inv_c;
  assign y  = (aa & bb) | (aa & cc) | (bb & cc);

endmodule

// File: rtl/mig_eval_seq.sv
// Programmable MIG evaluator, one MAJ3 node per cycle; result after cfg_len+1 cycles (immediately when cfg_len==0).
// Result is held in DONE until out_ready; no new vector is accepted until the result is taken.
module mig_eval_seq
  import mig_pkg::*;
#(
  parameter  int NUM_IN    = 7,
  parameter  int MAX_NODES = 8,
  localparam int IDX_W     = idx_w(NUM_IN, MAX_NODES),
  localparam int AW        = $clog2(MAX_NODES),
  localparam int LW        = $clog2(MAX_NODES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [3*(IDX_W+1)-1:0] cfg_data,
  input  logic                   cfg_ctrl_we,
  input  logic [LW-1:0]          cfg_len,
  input  logic [IDX_W-1:0]       cfg_out_sel,
  input  logic                   cfg_out_inv,
  output logic                   cfg_err,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_IN-1:0]      in_x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_y,
  output logic                   out_err
);

  localparam int SIG_N = NUM_IN + 1 + MAX_NODES;

  state_t               state, state_nx;
  node_t                prog [MAX_NODES];
  logic [NUM_IN-1:0]    x_q;
  logic [MAX_NODES-1:0] node_q;
  logic [LW-1:0]        cnt, len_q, eff_len;
  logic [IDX_W-1:0]     sel_q;
  logic                 inv_q, err_q, cfg_err_q;
  logic [SIG_N-1:0]     sig;

  node_t cur;
  logic  a_ok, b_ok, c_ok, a_v, b_v, c_v, maj_y, node_err, step;
  logic  cfg_any, addr_bad, len_bad, cfg_rej, cfg_ok, acc;
  logic  sel_ok, sel_v;

  function automatic logic opnd_ok(input logic [IDX_W-1:0] idx, input logic [LW-1:0] k);
    return int'(idx) < NUM_IN + 1 + int'(k);
  endfunction

  // Node slots at or beyond cfg_len are not part of this evaluation.
  function automatic logic sel_legal(input logic [IDX_W-1:0] s, input logic [LW-1:0] len);
    return (int'(s) <= NUM_IN) || (int'(s) - NUM_IN - 1 < int'(len));
  endfunction

  assign sig = {node_q, x_q, 1'b0};

  assign cur  = prog[cnt[AW-1:0]];
  assign a_ok = opnd_ok(cur.idx_a, cnt);
  assign b_ok = opnd_ok(cur.idx_b, cnt);
  assign c_ok = opnd_ok(cur.idx_c, cnt);
  assign a_v  = a_ok ? sig[cur.idx_a] : 1'b0;
  assign b_v  = b_ok ? sig[cur.idx_b] : 1'b0;
  assign c_v  = c_ok ? sig[cur.idx_c] : 1'b0;
  assign node_err = ~(a_ok & b_ok & c_ok);

  mig_maj3 u_maj (
    .a     (a_v),
    .b     (b_v),
    .c     (c_v),
    .inv_a (cur.inv_a),
    .inv_b (cur.inv_b),
    .inv_c (cur.inv_c),
    .y     (maj_y)
  );

  assign step = (state == EVAL) && (cnt < len_q);

  generate
    if ((1 << AW) > MAX_NODES) begin : g_addr_chk
      assign addr_bad = cfg_we && (int'(cfg_addr) >= MAX_NODES);
    end else begin : g_addr_full
      assign addr_bad = 1'b0;
    end
  endgenerate

  assign len_bad = cfg_ctrl_we && (cfg_len > LW'(MAX_NODES));
  assign cfg_any = cfg_we | cfg_ctrl_we;
  assign cfg_rej = cfg_any && ((state != IDLE) || addr_bad || len_bad);
  assign cfg_ok  = cfg_any && !cfg_rej;
  assign acc     = in_valid && in_ready;
  // A length written alongside the accept governs this evaluation.
  assign eff_len = (cfg_ok && cfg_ctrl_we) ? cfg_len : len_q;

  assign sel_ok = sel_legal(sel_q, len_q);
  assign sel_v  = sel_ok ? sig[sel_q] : 1'b0;

  assign cfg_err = cfg_err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_y     = 1'b0;
    out_err   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (eff_len == '0) ? DONE : EVAL;
      end
      EVAL: begin
        if (cnt == len_q) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_y     = sel_v ^ inv_q;
        out_err   = err_q | ~sel_ok;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      node_q    <= '0;
      cnt       <= '0;
      len_q     <= '0;
      sel_q     <= '0;
      inv_q     <= 1'b0;
      err_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < MAX_NODES; i++) prog[i] <= '0;
    end else begin
      cfg_err_q <= cfg_rej;
      if (cfg_ok && cfg_we) prog[cfg_addr] <= node_t'(cfg_data);
      if (cfg_ok && cfg_ctrl_we) begin
        len_q <= cfg_len;
        sel_q <= cfg_out_sel;
        inv_q <= cfg_out_inv;
      end
      if (acc) begin
        x_q    <= in_x;
        node_q <= '0;
        err_q  <= 1'b0;
        cnt    <= '0;
      end else if (step) begin
        node_q[cnt[AW-1:0]] <= maj_y;
        err_q               <= err_q | node_err;
        cnt                 <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mig_eval_seq.sv
// Self-checking bench for mig_eval_seq: vector table plus hand-written multi-cycle sequences.
module tb_mig_eval_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [14:0] cfg_data;
  logic        cfg_ctrl_we;
  logic [3:0]  cfg_len;
  logic [3:0]  cfg_out_sel;
  logic        cfg_out_inv;
  logic        cfg_err;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_x;
  logic        out_valid;
  logic        out_ready;
  logic        out_y;
  logic        out_err;

  mig_eval_seq dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ctrl_we(cfg_ctrl_we), .cfg_len(cfg_len), .cfg_out_sel(cfg_out_sel),
    .cfg_out_inv(cfg_out_inv), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic y;
    logic err;
    int   lat;
  } exp_t;

  typedef struct {
    int         prog;
    logic [6:0] x;
    logic       y;
    logic       err;
    int         lat;
  } vec_t;

  exp_t sb[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   acc_cyc = 0;

  task automatic chk(input string nm, input int act, input int req);
    ntests++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  task automatic wr_node(input int a, input logic ia, input int xa, input logic ib,
                         input int xb, input logic ic, input int xc);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = a[2:0];
    cfg_data = {ia, xa[3:0], ib, xb[3:0], ic, xc[3:0]};
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic wr_ctrl(input int len, input int sel, input logic inv);
    @(negedge clk);
    cfg_ctrl_we = 1'b1;
    cfg_len     = len[3:0];
    cfg_out_sel = sel[3:0];
    cfg_out_inv = inv;
    @(posedge clk);
    #1 cfg_ctrl_we = 1'b0;
  endtask

  task automatic accept(input logic [6:0] x, input logic ey, input logic ee, input int lat);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = x;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    sb.push_back('{y: ey, err: ee, lat: lat});
  endtask

  task automatic finish(input string nm, input int hold);
    exp_t e;
    int   n = 0;
    logic busy_ok = 1'b1;
    logic y0;
    while (!out_valid && n < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) chk({nm, "_timeout"}, 0, 1);
    e = sb.pop_front();
    chk({nm, "_lat"}, cyc - acc_cyc, e.lat);
    chk({nm, "_y"}, int'(out_y), int'(e.y));
    chk({nm, "_err"}, int'(out_err), int'(e.err));
    if (e.lat > 1) chk({nm, "_busy"}, int'(busy_ok), 1);
    if (hold > 0) begin
      y0       = out_y;
      in_valid = 1'b1;
      in_x     = 7'h55;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk({nm, "_hold_vld"}, int'(out_valid), 1);
        chk({nm, "_hold_y"}, int'(out_y), int'(y0));
        chk({nm, "_hold_rdy"}, int'(in_ready), 0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({nm, "_rdy_after"}, int'(in_ready), 1);
    chk({nm, "_vld_after"}, int'(out_valid), 0);
  endtask

  task automatic load(input int id);
    case (id)
      0: begin wr_node(0, 0, 1, 0, 2, 0, 3); wr_ctrl(1, 8, 1'b0); end
      1: begin wr_node(0, 1, 1, 0, 2, 0, 0); wr_ctrl(1, 8, 1'b0); end
      2: wr_ctrl(0, 3, 1'b1);
      default: wr_ctrl(1, 9, 1'b0);
    endcase
  endtask

  task automatic load_chain();
    wr_node(0, 0, 1, 0, 2, 0, 3);
    for (int k = 1; k < 6; k++) wr_node(k, 1, 8 + k - 1, 0, k + 1, 1, 0);
    wr_ctrl(6, 13, 1'b0);
  endtask

  // Node0 = MAJ(x0,x1,x2); node k = MAJ(~node(k-1), x[k], 1) = ~node(k-1) | x[k].
  function automatic logic chain_ref(input logic [6:0] x);
    logic p;
    p = (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
    for (int k = 1; k < 6; k++) p = ~p | x[k];
    return p;
  endfunction

  vec_t tbl[15];
  logic [6:0] cx;

  initial begin
    tbl[0]  = '{0, 7'b0000011, 1'b1, 1'b0, 2};
    tbl[1]  = '{0, 7'b0000001, 1'b0, 1'b0, 2};
    tbl[2]  = '{0, 7'b0000111, 1'b1, 1'b0, 2};
    tbl[3]  = '{0, 7'b1111100, 1'b0, 1'b0, 2};
    tbl[4]  = '{0, 7'b0000110, 1'b1, 1'b0, 2};
    tbl[5]  = '{1, 7'b0000010, 1'b1, 1'b0, 2};
    tbl[6]  = '{1, 7'b0000011, 1'b0, 1'b0, 2};
    tbl[7]  = '{1, 7'b0000000, 1'b0, 1'b0, 2};
    tbl[8]  = '{1, 7'b1111110, 1'b1, 1'b0, 2};
    tbl[9]  = '{1, 7'b1111101, 1'b0, 1'b0, 2};
    tbl[10] = '{2, 7'b0000100, 1'b0, 1'b0, 0};
    tbl[11] = '{2, 7'b0000000, 1'b1, 1'b0, 0};
    tbl[12] = '{2, 7'b1111011, 1'b1, 1'b0, 0};
    tbl[13] = '{3, 7'b0000010, 1'b0, 1'b1, 2};
    tbl[14] = '{3, 7'b1111111, 1'b0, 1'b1, 2};

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_ctrl_we = 1'b0;
    cfg_len = '0; cfg_out_sel = '0; cfg_out_inv = 1'b0;
    in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_y", int'(out_y), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0, cur = -1; i < 15; i++) begin
      if (tbl[i].prog != cur) begin
        load(tbl[i].prog);
        cur = tbl[i].prog;
      end
      accept(tbl[i].x, tbl[i].y, tbl[i].err, tbl[i].lat);
      finish($sformatf("vec%0d", i), 0);
    end

    // Six-node chain: latency 7 and in_ready low throughout.
    load_chain();
    for (int i = 0; i < 3; i++) begin
      cx = (i == 0) ? 7'b0000000 : (i == 1) ? 7'b0100000 : 7'b0000111;
      accept(cx, chain_ref(cx), 1'b0, 7);
      finish($sformatf("chain%0d", i), 0);
    end

    // Result held under backpressure.
    load(0);
    accept(7'b0000011, 1'b1, 1'b0, 2);
    finish("hold", 5);

    // Self reference reads 0; config write during EVAL is rejected.
    wr_node(0, 0, 1, 0, 2, 0, 3);
    wr_node(1, 0, 8, 0, 1, 0, 9);
    wr_ctrl(2, 9, 1'b0);
    accept(7'b0000011, 1'b1, 1'b1, 3);
    wr_node(0, 1, 0, 1, 0, 1, 0);
    chk("cfg_err_pulse", int'(cfg_err), 1);
    @(posedge clk);
    #1 chk("cfg_err_clear", int'(cfg_err), 0);
    finish("selfref", 0);
    accept(7'b0000001, 1'b0, 1'b1, 3);
    finish("prog_kept", 0);
    wr_ctrl(9, 8, 1'b1);
    chk("len_bad_err", int'(cfg_err), 1);
    accept(7'b0000011, 1'b1, 1'b1, 3);
    finish("len_kept", 0);

    // Reset in the third EVAL cycle.
    load_chain();
    accept(7'b1111111, 1'b0, 1'b0, 7);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    @(negedge clk) rst = 1'b0;
    void'(sb.pop_front());
    accept(7'b1111111, 1'b0, 1'b0, 0);
    finish("post_rst_len0", 0);
    wr_ctrl(0, 0, 1'b1);
    accept(7'b1111111, 1'b1, 1'b0, 0);
    finish("post_rst_inv", 0);
    wr_ctrl(1, 8, 1'b0);
    accept(7'b1111111, 1'b0, 1'b0, 2);
    finish("post_rst_cleared", 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0, want 1");
    $fatal(1, "timeout");
  end

endmodule
